// File: rtl/pc_sequencer.sv
// LEGLite fetch/execute sequencer.
// Owns the program counter and steps it through a request/execute/retire
// sequence against an instruction memory with a ready handshake. Provides
// a terminal halt, a sticky fetch-timeout flag and a retired-instruction
// counter for the CPU top level.
module pc_sequencer #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int          MAX_WAIT    = 15,
  parameter int          COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [15:0]            imem_addr,
  input  logic                   imem_ready,
  input  logic [15:0]            imem_rdata,
  output logic [15:0]            instr,
  output logic                   instr_valid,
  input  logic                   stall,
  input  logic [15:0]            signext,
  input  logic                   branch,
  input  logic                   uncondbranch,
  input  logic                   alu_zero,
  input  logic                   halt,
  output logic [15:0]            pc,
  output logic                   halted,
  output logic                   fetch_error,
  output logic [COUNT_WIDTH-1:0] retired
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_EXEC = 2'd1,
    S_HALT = 2'd2
  } state_t;

  // Wait-counter value at which the current not-ready cycle is the last
  // one tolerated; the counter never needs more than 8 bits (MAX_WAIT<=255).
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t                 state, state_nxt;
  logic [15:0]            pc_nxt;
  logic [15:0]            instr_nxt;
  logic [7:0]             wait_cnt, wait_nxt;
  logic                   fetch_error_nxt;
  logic [COUNT_WIDTH-1:0] retired_nxt;
  logic                   take_branch;

  // Branch-resolved successor of cur_pc. The offset counts instructions,
  // so it is doubled into bytes; the bit shifted out of the top is lost
  // and the sum wraps modulo 2^16.
  function automatic logic [15:0] next_pc(input logic [15:0] cur_pc,
                                          input logic [15:0] offset,
                                          input logic        taken);
    logic signed [15:0] byte_off;
    byte_off = $signed(offset) <<< 1;
    if (taken)
      next_pc = cur_pc + $unsigned(byte_off);
    else
      next_pc = cur_pc + 16'd2;
  endfunction

  assign imem_req    = (state == S_REQ);
  assign instr_valid = (state == S_EXEC);
  assign halted      = (state == S_HALT);
  assign imem_addr   = pc;

  // CBZ taken on zero flag; unconditional always taken; both set counts as taken.
  assign take_branch = (branch & alu_zero) | uncondbranch;

  // Next-state and next-value logic for the fetch/execute sequence.
  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    instr_nxt       = instr;
    wait_nxt        = wait_cnt;
    fetch_error_nxt = fetch_error;
    retired_nxt     = retired;
    case (state)
      S_REQ: begin
        if (imem_ready) begin
          instr_nxt = imem_rdata;
          wait_nxt  = 8'd0;
          state_nxt = S_EXEC;
        end else begin
          wait_nxt = wait_cnt + 8'd1;
          if (wait_cnt == WAIT_LAST) begin
            fetch_error_nxt = 1'b1;
            state_nxt       = S_HALT;
          end
        end
      end
      S_EXEC: begin
        // Retire only once the datapath releases the stall.
        if (!stall) begin
          retired_nxt = retired + COUNT_WIDTH'(1);
          if (halt) begin
            state_nxt = S_HALT;
          end else begin
            pc_nxt    = next_pc(pc, signext, take_branch);
            state_nxt = S_REQ;
          end
        end
      end
      S_HALT: begin
        state_nxt = S_HALT;
      end
      default: begin
        state_nxt = S_REQ;
      end
    endcase
  end

  // State and architectural registers; reset overrides any pending fetch or execute.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      instr       <= 16'h0000;
      wait_cnt    <= 8'd0;
      fetch_error <= 1'b0;
      retired     <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      instr       <= instr_nxt;
      wait_cnt    <= wait_nxt;
      fetch_error <= fetch_error_nxt;
      retired     <= retired_nxt;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: straight-line fetch, branch variants,
// pc and counter wrap, stalls, fetch timeout, halt and reset override.
// A 4-bit retired counter keeps the wrap check short.
module tb_pc_sequencer;

  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          imem_req;
  logic [15:0]   imem_addr;
  logic          imem_ready;
  logic [15:0]   imem_rdata;
  logic [15:0]   instr;
  logic          instr_valid;
  logic          stall;
  logic [15:0]   signext;
  logic          branch;
  logic          uncondbranch;
  logic          alu_zero;
  logic          halt;
  logic [15:0]   pc;
  logic          halted;
  logic          fetch_error;
  logic [CW-1:0] retired;

  int n_checks = 0;
  int n_errors = 0;

  pc_sequencer #(
    .RESET_PC(16'h0000),
    .MAX_WAIT(15),
    .COUNT_WIDTH(CW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .instr(instr),
    .instr_valid(instr_valid),
    .stall(stall),
    .signext(signext),
    .branch(branch),
    .uncondbranch(uncondbranch),
    .alu_zero(alu_zero),
    .halt(halt),
    .pc(pc),
    .halted(halted),
    .fetch_error(fetch_error),
    .retired(retired)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One REQ cycle with ready; lands in EXEC with the word latched.
  task automatic do_fetch(input logic [15:0] w, input string tag);
    check({tag, "_req"}, {31'd0, imem_req}, 32'd1);
    imem_ready = 1'b1;
    imem_rdata = w;
    tick();
    imem_ready = 1'b0;
    imem_rdata = 16'h0000;
    check({tag, "_instr"}, {16'd0, instr}, {16'd0, w});
    check({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
  endtask

  // One EXEC cycle without stall; branch controls applied for that cycle only.
  task automatic do_retire(input logic br, input logic uc, input logic z,
                           input logic [15:0] se, input logic h);
    branch = br; uncondbranch = uc; alu_zero = z; signext = se; halt = h;
    stall = 1'b0;
    tick();
    branch = 1'b0; uncondbranch = 1'b0; alu_zero = 1'b0; signext = 16'h0000; halt = 1'b0;
  endtask

  initial begin
    int cnt;
    reset = 1'b1; imem_ready = 1'b1; imem_rdata = 16'h5555; stall = 1'b0;
    signext = 16'h0000; branch = 1'b0; uncondbranch = 1'b0; alu_zero = 1'b0; halt = 1'b0;
    tick();
    tick();
    reset = 1'b0; imem_ready = 1'b0;
    // Reset state: ready during reset must not load instr.
    check("rst_pc",    {16'd0, pc}, 32'h0000);
    check("rst_instr", {16'd0, instr}, 32'h0000);
    check("rst_ret",   {28'd0, retired}, 32'd0);
    check("rst_halt",  {31'd0, halted}, 32'd0);
    check("rst_ferr",  {31'd0, fetch_error}, 32'd0);
    check("rst_ival",  {31'd0, instr_valid}, 32'd0);

    // Straight-line stream.
    check("t1_addr0", {16'd0, imem_addr}, 32'h0000);
    do_fetch(16'h1111, "t1_f0");
    check("t1_reqlow", {31'd0, imem_req}, 32'd0);
    do_retire(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    check("t1_addr1", {16'd0, imem_addr}, 32'h0002);
    do_fetch(16'h2222, "t1_f1");
    do_retire(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    check("t1_addr2", {16'd0, imem_addr}, 32'h0004);
    do_fetch(16'h3333, "t1_f2");

    // Branches: CBZ taken, backward unconditional, CBZ not taken, both set.
    do_retire(1'b1, 1'b0, 1'b1, 16'h0003, 1'b0);
    check("t1_ret3",   {28'd0, retired}, 32'd3);
    check("t2_cbz",    {16'd0, imem_addr}, 32'h000A);
    do_fetch(16'h4444, "t2_f3");
    do_retire(1'b0, 1'b1, 1'b0, 16'hFFFE, 1'b0);
    check("t2_back",   {16'd0, imem_addr}, 32'h0006);
    do_fetch(16'h5555, "t2_f4");
    do_retire(1'b1, 1'b0, 1'b0, 16'h0003, 1'b0);
    check("t2_nottkn", {16'd0, imem_addr}, 32'h0008);
    do_fetch(16'h6666, "t2_f5");
    do_retire(1'b1, 1'b1, 1'b0, 16'h0004, 1'b0);
    check("t2_both",   {16'd0, imem_addr}, 32'h0010);
    check("t2_ret",    {28'd0, retired}, 32'd6);

    // PC wrap: 0x0010 + (0x7FF7<<1) = 0xFFFE, then +2 wraps to 0.
    do_fetch(16'h7777, "t3_f0");
    do_retire(1'b0, 1'b1, 1'b0, 16'h7FF7, 1'b0);
    check("t3_fffe", {16'd0, pc}, 32'hFFFE);
    do_fetch(16'h8888, "t3_f1");
    do_retire(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    check("t3_wrap", {16'd0, pc}, 32'h0000);
    check("t3_ret",  {28'd0, retired}, 32'd8);

    // Stall for 3 cycles: branch inputs present but ignored while stalled.
    do_fetch(16'hABCD, "t4_f");
    stall = 1'b1; uncondbranch = 1'b1; signext = 16'h0040;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_valid", {31'd0, instr_valid}, 32'd1);
      check("t4_pc",    {16'd0, pc}, 32'h0000);
      check("t4_ret",   {28'd0, retired}, 32'd8);
      check("t4_instr", {16'd0, instr}, 32'h0000ABCD);
    end
    uncondbranch = 1'b0; signext = 16'h0000;
    do_retire(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    check("t4_pc2",  {16'd0, pc}, 32'h0002);
    check("t4_ret2", {28'd0, retired}, 32'd9);

    // Retired counter wrap at 2^CW.
    for (int i = 0; i < 6; i++) begin
      do_fetch(16'h0100 + 16'(i), "t3c_f");
      do_retire(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    end
    check("t3_ret15", {28'd0, retired}, 32'd15);
    check("t3_pc0e",  {16'd0, pc}, 32'h000E);
    do_fetch(16'h0200, "t3c_g");
    do_retire(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    check("t3_retwrap", {28'd0, retired}, 32'd0);
    check("t3_pc10",    {16'd0, pc}, 32'h0010);

    // Halt beats unconditional branch.
    do_fetch(16'hDEAD, "t6_f");
    do_retire(1'b0, 1'b1, 1'b0, 16'h0005, 1'b1);
    check("t6_halted", {31'd0, halted}, 32'd1);
    check("t6_pc",     {16'd0, pc}, 32'h0010);
    check("t6_ret",    {28'd0, retired}, 32'd1);
    imem_ready = 1'b1; imem_rdata = 16'h1234; uncondbranch = 1'b1; signext = 16'h0008;
    tick();
    tick();
    imem_ready = 1'b0; uncondbranch = 1'b0; signext = 16'h0000;
    check("t6_frz_halt",  {31'd0, halted}, 32'd1);
    check("t6_frz_pc",    {16'd0, pc}, 32'h0010);
    check("t6_frz_instr", {16'd0, instr}, 32'h0000DEAD);
    check("t6_frz_ret",   {28'd0, retired}, 32'd1);
    check("t6_frz_req",   {31'd0, imem_req}, 32'd0);
    check("t6_frz_ferr",  {31'd0, fetch_error}, 32'd0);

    // Fetch timeout: count REQ cycles with ready held low.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cnt = 0;
    while (imem_req && cnt < 40) begin
      cnt++;
      tick();
    end
    check("t5_reqcyc", cnt, 32'd15);
    check("t5_ferr",   {31'd0, fetch_error}, 32'd1);
    check("t5_halted", {31'd0, halted}, 32'd1);
    check("t5_req",    {31'd0, imem_req}, 32'd0);
    imem_ready = 1'b1;
    tick();
    tick();
    imem_ready = 1'b0;
    check("t5_stay", {30'd0, fetch_error, halted}, 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_clr", {29'd0, fetch_error, halted, imem_req}, 32'd1);

    // Reset during a pending fetch; ready in the reset cycle is ignored.
    do_fetch(16'hBEEF, "t6b_f");
    do_retire(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    check("t6b_pc2", {16'd0, pc}, 32'h0002);
    tick();
    tick();
    reset = 1'b1; imem_ready = 1'b1; imem_rdata = 16'h7777;
    tick();
    reset = 1'b0; imem_ready = 1'b0; imem_rdata = 16'h0000;
    check("t6b_pc",    {16'd0, pc}, 32'h0000);
    check("t6b_instr", {16'd0, instr}, 32'h0000);
    check("t6b_req",   {31'd0, imem_req}, 32'd1);
    tick();
    check("t6b_instr2", {16'd0, instr}, 32'h0000);
    check("t6b_ival",   {31'd0, instr_valid}, 32'd0);
    check("t6b_ret",    {28'd0, retired}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Multi-cycle fetch/execute sequencer that owns the LEGLite program counter and drives it through an instruction-memory handshake. It replaces the free-running every-clock PC update with a controlled sequence:
- request the instruction at pc and wait for memory ready;
- present the instruction to decode/execute and hold while the datapath stalls;
- retire with the branch-resolved next PC.

It also provides halt, fetch-timeout and retired-instruction-count facilities for the CPU top level.

Parameters:
RESET_PC, 16'h0000, pc value loaded on reset.
MAX_WAIT, 15, consecutive REQ cycles without imem_ready before a fetch timeout (legal range 1..255).
COUNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high
imem_req  output  1  instruction fetch request, high only in REQ
imem_addr  output  16  fetch address, equals pc
imem_ready  input  1  memory returns imem_rdata valid this cycle; sampled only in REQ
imem_rdata  input  16  instruction word from memory
instr  output  16  latched instruction register
instr_valid  output  1  high while in EXEC (instr usable by decode/execute)
stall  input  1  datapath not ready to retire; holds EXEC
signext  input  16  sign-extended branch offset in instructions (two's complement)
branch  input  1  conditional branch (CBZ) decoded
uncondbranch  input  1  unconditional branch decoded
alu_zero  input  1  ALU zero flag
halt  input  1  halt instruction decoded; sampled at retire
pc  output  16  current program counter
halted  output  1  high in HALT state
fetch_error  output  1  sticky, set on fetch timeout
retired  output  COUNT_WIDTH  count of retired instructions

Behaviour:
- Reset state (next edge after reset=1; overrides everything, including mid-WAIT or mid-EXEC):
  - state=REQ, pc=RESET_PC, instr=0, fetch_error=0, retired=0, wait counter=0.
  - Any imem_ready seen in the reset cycle is ignored.
- States: REQ, EXEC, HALT. Encoding is free.
- Outputs are decoded from state:
  - imem_req=(state==REQ)
  - instr_valid=(state==EXEC)
  - halted=(state==HALT)
  - imem_addr=pc at all times.
- REQ:
  - imem_ready=1: instr<=imem_rdata, wait counter<=0, next=EXEC.
  - imem_ready=0: wait counter increments. When it would reach MAX_WAIT, fetch_error<=1 and next=HALT. A fetch with MAX_WAIT=15 therefore times out on the 15th consecutive not-ready cycle.
- EXEC:
  - stall=1: remain in EXEC; pc, instr and retired are unchanged. Branch inputs are ignored until stall drops.
  - stall=0 (retire): retired<=retired+1, wrapping modulo 2^COUNT_WIDTH. Then:
    - halt=1: pc unchanged, next=HALT. halt has priority over branches.
    - else if (branch & alu_zero) | uncondbranch: pc<=pc+(signext<<1), next=REQ.
    - else: pc<=pc+2, next=REQ.
- PC arithmetic:
  - 16-bit, wraps modulo 2^16; the shifted-out bit of signext is discarded.
  - Negative signext gives a backward branch.
  - branch=1 with alu_zero=0 takes the pc+2 path.
  - branch and uncondbranch both 1 is treated as taken.
- Timing: minimum 2 cycles per instruction (ready in the first REQ cycle). The fetch address for the next instruction appears the cycle after retire.
- HALT:
  - Terminal; exits only via reset.
  - pc, instr, retired and fetch_error frozen; imem_req=0; all inputs ignored.
- imem_ready outside REQ is ignored. imem_rdata is sampled only on the REQ/ready cycle.

Test Plan:
1. Reset, then imem_ready=1 every REQ cycle, no branches, instruction stream 0x1111, 0x2222, 0x3333 -> imem_addr 0x0000, 0x0002, 0x0004 on alternate cycles; instr matches each word; retired=3 after the third retire.
2. At pc=0x0004: branch=1, alu_zero=1, signext=0x0003 -> next fetch 0x000A. Then uncondbranch=1, signext=0xFFFE -> next fetch 0x0006. Then branch=1, alu_zero=0 -> next fetch 0x0008.
3. pc=0xFFFE via branch, no-branch retire -> pc wraps to 0x0000. retired at 0xFFFF, one more retire -> 0x0000.
4. stall held 3 cycles in EXEC with instr=0xABCD -> instr_valid high 4 cycles; pc and retired constant until stall falls; single increment afterwards.
5. imem_ready held 0, MAX_WAIT=15 -> imem_req high for 15 cycles, then fetch_error=1, halted=1, imem_req=0; stays there until reset clears all three.
6. halt=1 with uncondbranch=1 at retire, pc=0x0010 -> halted=1, pc stays 0x0010, retired increments once. Separately, reset asserted during a pending REQ -> pc=RESET_PC, and a late imem_ready does not load instr.
